qspi_target: RTL

//  QSPI responder (target) side of the memory interface: decodes host command/address

---
 rtl/qspi_pkg.sv | 20 ++
 rtl/qspi_if.sv | 31 +++
 rtl/qspi_sync_edge.sv | 32 +++
 rtl/qspi_target.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared opcodes, frame geometry and FSM state encoding for the QSPI target.
package qspi_pkg;

    localparam logic [7:0] QSPI_CMD_QREAD  = 8'hEB;
    localparam logic [7:0] QSPI_CMD_QWRITE = 8'h38;

    localparam int unsigned ADDR_NIBBLES = 6;
    localparam int unsigned CMD_BITS     = 8;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StRdata,
        StWdata,
        StIgnore
    } qspi_state_e;

endpackage

// File: rtl/qspi_if.sv
// QSPI pin bundle plus the byte-wide SRAM port served by the target.
interface qspi_if
    import qspi_pkg::*;
#(
    parameter int unsigned MEM_AW = 8
) ();

    logic              qspi_sck;
    logic              qspi_cs_n;
    logic [3:0]        qspi_io_in;
    logic [3:0]        qspi_io_out;
    logic [3:0]        qspi_io_oe;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    // Host and SRAM side.
    modport master (
        output qspi_sck, qspi_cs_n, qspi_io_in, mem_rdata,
        input  qspi_io_out, qspi_io_oe, mem_addr, mem_wdata, mem_we, mem_re
    );

    // Target side.
    modport slave (
        input  qspi_sck, qspi_cs_n, qspi_io_in, mem_rdata,
        output qspi_io_out, qspi_io_oe, mem_addr, mem_wdata, mem_we, mem_re
    );

endinterface

// File: rtl/qspi_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, with 1-clk rise/fall pulses.
module qspi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // Synchronise, then keep one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
            s3 <= RESET_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/qspi_target.sv
// QSPI target: decodes quad read/write frames and serves them from a byte-wide SRAM port.
module qspi_target
    import qspi_pkg::*;
#(
    parameter int unsigned MEM_AW       = 8,
    parameter int unsigned DUMMY_CYCLES = 4
) (
    input  logic  clk,
    input  logic  rst,
    qspi_if.slave bus,
    output logic  busy
);

    logic sck_rise, sck_fall, unused_sck_level;
    logic cs_s, unused_cs_rise, unused_cs_fall;
    logic [3:0] io_meta, io_s;

    qspi_sync_edge #(
        .RESET_VAL (1'b0)
    ) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.qspi_sck),
        .q    (unused_sck_level),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    qspi_sync_edge #(
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.qspi_cs_n),
        .q    (cs_s),
        .rise (unused_cs_rise),
        .fall (unused_cs_fall)
    );

    // IO synchronised with the same latency as SCK, so it is stable on a rise pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_meta <= 4'h0;
            io_s    <= 4'h0;
        end else begin
            io_meta <= bus.qspi_io_in;
            io_s    <= io_meta;
        end
    end

    qspi_state_e       state;
    logic [3:0]        cnt;
    logic [7:0]        cmd_sh;
    logic [23:0]       addr_sh;
    logic [7:0]        data_sh;
    logic [7:0]        pf;
    logic [MEM_AW-1:0] addr;
    logic [3:0]        io_out;
    logic [3:0]        io_oe;
    logic [7:0]        wdata;
    logic              mem_we;
    logic              mem_re;
    logic              rd_pend;
    logic              nib_hi;

    logic [7:0]  cmd_next;
    logic [23:0] addr_next;
    logic        unused_addr;

    // Shift-in candidates for the command and address registers.
    always_comb begin
        cmd_next  = {cmd_sh[6:0], io_s[0]};
        addr_next = {addr_sh[19:0], io_s};
    end

    // Upper address bits are received but not stored beyond MEM_AW.
    assign unused_addr = ^{addr_sh[23:20], addr_next};

    // Capture SRAM read data the clk after each read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            pf      <= 8'h00;
        end else begin
            rd_pend <= mem_re;
            if (rd_pend) begin
                pf <= bus.mem_rdata;
            end
        end
    end

    // Frame FSM with registered pin and SRAM outputs; CS_n high always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            cnt     <= 4'd0;
            cmd_sh  <= 8'h00;
            addr_sh <= 24'h0;
            data_sh <= 8'h00;
            addr    <= '0;
            io_out  <= 4'h0;
            io_oe   <= 4'h0;
            wdata   <= 8'h00;
            mem_we  <= 1'b0;
            mem_re  <= 1'b0;
            nib_hi  <= 1'b1;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            // Post-increment after a write strobe has been presented.
            if (mem_we) begin
                addr <= addr + MEM_AW'(1);
            end
            if (cs_s) begin
                state  <= StIdle;
                cnt    <= 4'd0;
                io_oe  <= 4'h0;
                io_out <= 4'h0;
                nib_hi <= 1'b1;
            end else begin
                case (state)
                    StIdle: begin
                        state <= StCmd;
                        cnt   <= 4'd0;
                    end
                    StCmd: begin
                        if (sck_rise) begin
                            cmd_sh <= cmd_next;
                            if (cnt == 4'(CMD_BITS - 1)) begin
                                cnt <= 4'd0;
                                if (cmd_next == QSPI_CMD_QREAD || cmd_next == QSPI_CMD_QWRITE) begin
                                    state <= StAddr;
                                end else begin
                                    state <= StIgnore;
                                end
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                    StAddr: begin
                        if (sck_rise) begin
                            addr_sh <= addr_next;
                            if (cnt == 4'(ADDR_NIBBLES - 1)) begin
                                cnt    <= 4'd0;
                                addr   <= addr_next[MEM_AW-1:0];
                                nib_hi <= 1'b1;
                                if (cmd_sh == QSPI_CMD_QREAD) begin
                                    mem_re <= 1'b1;
                                    state  <= StDummy;
                                end else begin
                                    state <= StWdata;
                                end
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                    StDummy: begin
                        if (sck_rise) begin
                            if (cnt == 4'(DUMMY_CYCLES - 1)) begin
                                cnt     <= 4'd0;
                                state   <= StRdata;
                                data_sh <= pf;
                                nib_hi  <= 1'b1;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                    StRdata: begin
                        if (sck_fall) begin
                            io_oe <= 4'hF;
                            if (nib_hi) begin
                                // Start prefetch of the next byte while this one shifts out.
                                io_out <= data_sh[7:4];
                                addr   <= addr + MEM_AW'(1);
                                mem_re <= 1'b1;
                                nib_hi <= 1'b0;
                            end else begin
                                io_out  <= data_sh[3:0];
                                data_sh <= pf;
                                nib_hi  <= 1'b1;
                            end
                        end
                    end
                    StWdata: begin
                        if (sck_rise) begin
                            if (nib_hi) begin
                                data_sh[7:4] <= io_s;
                                nib_hi       <= 1'b0;
                            end else begin
                                wdata  <= {data_sh[7:4], io_s};
                                mem_we <= 1'b1;
                                nib_hi <= 1'b1;
                            end
                        end
                    end
                    StIgnore: begin
                        state <= StIgnore;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.qspi_io_out = io_out;
    assign bus.qspi_io_oe  = io_oe;
    assign bus.mem_addr    = addr;
    assign bus.mem_wdata   = wdata;
    assign bus.mem_we      = mem_we;
    assign bus.mem_re      = mem_re;

    assign busy = ~cs_s && (state != StIdle);

endmodule
